// File: rtl/rr_select_arbiter8.sv
// Round-robin arbiter sharing one 8-way select between 8 requesters, with break-before-make
// spacing and a hold limit on each grant's tenure.
module rr_select_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] sel_idx,
  output logic       sel_valid,
  output logic       preempt,
  output logic       busy
);

  localparam logic [CNT_W-1:0] HoldMax = CNT_W'(MAX_HOLD);

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StGap
  } state_e;

  state_e           state;
  logic [2:0]       ptr;
  logic [CNT_W-1:0] hold_cnt;

  logic [2:0] win_idx;
  logic       win_found;
  logic       others_pending;

  // First requester at or after ptr, wrapping 7->0; 3-bit addition wraps for free.
  always_comb begin
    win_idx   = ptr;
    win_found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!win_found && req[ptr + 3'(i)]) begin
        win_found = 1'b1;
        win_idx   = ptr + 3'(i);
      end
    end
  end

  assign others_pending = |(req & ~(8'b1 << sel_idx));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      gnt       <= '0;
      sel_idx   <= '0;
      sel_valid <= 1'b0;
      preempt   <= 1'b0;
      busy      <= 1'b0;
      ptr       <= '0;
      hold_cnt  <= '0;
    end else begin
      preempt <= 1'b0;
      case (state)
        StIdle, StGap: begin
          if (en && win_found) begin
            state     <= StGrant;
            sel_idx   <= win_idx;
            gnt       <= 8'b1 << win_idx;
            sel_valid <= 1'b1;
            busy      <= 1'b1;
            hold_cnt  <= CNT_W'(1);
          end else begin
            state <= StIdle;
            busy  <= 1'b0;
          end
        end
        StGrant: begin
          // Release has priority over expiry, so a release on the expiry edge never preempts.
          if (!req[sel_idx]) begin
            state     <= StGap;
            gnt       <= '0;
            sel_valid <= 1'b0;
            ptr       <= sel_idx + 3'd1;
          end else if (hold_cnt == HoldMax && others_pending) begin
            state     <= StGap;
            gnt       <= '0;
            sel_valid <= 1'b0;
            ptr       <= sel_idx + 3'd1;
            preempt   <= 1'b1;
          end else if (hold_cnt != HoldMax) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= StIdle;
          gnt       <= '0;
          sel_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_select_arbiter8.sv
// Scoreboard bench for rr_select_arbiter8: directed vectors push per-cycle expectations,
// a monitor pops and compares them against the registered outputs.
module tb_rr_select_arbiter8;

  localparam int unsigned MaxHold = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b0;
  logic [7:0] req   = 8'h00;
  logic [7:0] gnt;
  logic [2:0] sel_idx;
  logic       sel_valid;
  logic       preempt;
  logic       busy;

  rr_select_arbiter8 #(
    .MAX_HOLD(MaxHold),
    .CNT_W   (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .req      (req),
    .gnt      (gnt),
    .sel_idx  (sel_idx),
    .sel_valid(sel_valid),
    .preempt  (preempt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] gnt;
    logic       pre;
    logic       busy;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2:0] idx_of(input logic [7:0] oh);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (oh[i]) r = 3'(i);
    return r;
  endfunction

  // Monitor: wakes on each falling clock edge and on reset assertion.
  always @(negedge clk or negedge rst_n) begin
    exp_t e;
    logic ok;
    #1;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e  = q.pop_front();
      ok = (gnt === e.gnt) && (sel_valid === (e.gnt != 8'h00)) && (preempt === e.pre) &&
           (busy === e.busy) && ((e.gnt == 8'h00) || (sel_idx === idx_of(e.gnt)));
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL cycle %0d: got gnt=%h idx=%0d valid=%b pre=%b busy=%b, want gnt=%h pre=%b busy=%b",
                 e.cyc, gnt, sel_idx, sel_valid, preempt, busy, e.gnt, e.pre, e.busy);
      end
    end
  end

  // Applies inputs for the next rising edge and records the outputs expected after it.
  task automatic step(input logic e, input logic [7:0] r, input logic [7:0] eg,
                      input logic ep, input logic eb);
    exp_t x;
    en     = e;
    req    = r;
    x.cyc  = cyc + 1;
    x.gnt  = eg;
    x.pre  = ep;
    x.busy = eb;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input logic [7:0] eg, input logic ep, input logic eb);
    exp_t x;
    x.cyc  = cyc;
    x.gnt  = eg;
    x.pre  = ep;
    x.busy = eb;
    q.push_back(x);
  endtask

  // Asserts reset between edges; the outputs must drop with no clock edge in between.
  task automatic reset_mid();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    expect_now(8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    expect_now(8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d expectations pending", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] oh;
    repeat (2) @(posedge clk);
    #1;
    expect_now(8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

    // Single request, release, then pointer check (ptr=5 -> 7 wins over 0).
    step(1'b1, 8'h10, 8'h10, 1'b0, 1'b1);
    repeat (3) step(1'b1, 8'h10, 8'h10, 1'b0, 1'b1);
    step(1'b1, 8'h00, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h81, 8'h80, 1'b0, 1'b1);
    step(1'b1, 8'h00, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);

    // Hold expiry with contention: 4 cycles of 0, preempt, gap, 1, then 0 again.
    repeat (4) step(1'b1, 8'h03, 8'h01, 1'b0, 1'b1);
    step(1'b1, 8'h03, 8'h00, 1'b1, 1'b1);
    step(1'b1, 8'h03, 8'h02, 1'b0, 1'b1);
    step(1'b1, 8'h03, 8'h02, 1'b0, 1'b1);
    step(1'b1, 8'h01, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h01, 8'h01, 1'b0, 1'b1);
    step(1'b1, 8'h00, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);

    // Expiry without contention keeps the grant.
    repeat (20) step(1'b1, 8'h01, 8'h01, 1'b0, 1'b1);
    step(1'b1, 8'h00, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);

    // Enable gating, grant persisting with en low, release on the expiry edge.
    repeat (2) step(1'b0, 8'h20, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h20, 8'h20, 1'b0, 1'b1);
    repeat (3) step(1'b0, 8'h20, 8'h20, 1'b0, 1'b1);
    step(1'b1, 8'h01, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h81, 8'h80, 1'b0, 1'b1);
    step(1'b1, 8'h00, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);

    // Rotation 0..7,0 with one idle cycle between grants.
    for (int i = 0; i < 8; i++) begin
      oh = 8'h01 << i;
      repeat (3) step(1'b1, 8'hFF, oh, 1'b0, 1'b1);
      step(1'b1, 8'hFF & ~oh, 8'h00, 1'b0, 1'b1);
    end
    step(1'b1, 8'hFF, 8'h01, 1'b0, 1'b1);
    step(1'b1, 8'h00, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);

    // Async reset mid-grant; afterwards ptr is back at 0.
    step(1'b1, 8'h08, 8'h08, 1'b0, 1'b1);
    step(1'b1, 8'h08, 8'h08, 1'b0, 1'b1);
    reset_mid();
    step(1'b1, 8'h09, 8'h01, 1'b0, 1'b1);
    step(1'b1, 8'h08, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h08, 8'h08, 1'b0, 1'b1);
    step(1'b1, 8'h00, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
